// File: rtl/board_io_pkg.sv
// Shared constants and types for the board I/O conditioning block.
// Holds default parameter values and the default-width duty type.
package board_io_pkg;

  localparam int DebounceCyclesDefault = 50000;
  localparam int PwmWidthDefault       = 8;

  typedef logic [PwmWidthDefault-1:0] pwm_duty_t;

  // Width of a counter that must hold values 0..cycles.
  function automatic int cnt_width(input int cycles);
    return $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/debounce_chan.sv
// One debounced input channel: 2-flop synchroniser, mismatch counter,
// stable level and registered single-cycle rise/fall pulses.
module debounce_chan
  import board_io_pkg::*;
#(
  parameter int DebounceCycles = DebounceCyclesDefault
) (
  input  logic clk_sys_i,
  input  logic rst_sys_i,
  input  logic raw_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  localparam int              CntW    = cnt_width(DebounceCycles);
  localparam logic [CntW-1:0] CntLast = CntW'(DebounceCycles - 1);

  logic [1:0]      sync_q, sync_d;
  logic            stable_q, stable_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            rise_q, rise_d;
  logic            fall_q, fall_d;

  // NOTE: every signal gets a default before the if-tree so no path leaves it unassigned (no latch).
  always_comb begin
    sync_d   = {sync_q[0], raw_i};
    stable_d = stable_q;
    cnt_d    = '0;
    rise_d   = 1'b0;
    fall_d   = 1'b0;
    if (sync_q[1] != stable_q) begin
      if (cnt_q == CntLast) begin
        stable_d = sync_q[1];
        rise_d   = sync_q[1];
        fall_d   = ~sync_q[1];
      end else begin
        cnt_d = cnt_q + CntW'(1);
      end
    end
  end

  // NOTE: state flops use non-blocking assignments so all of them update from pre-edge values.
  always_ff @(posedge clk_sys_i or posedge rst_sys_i) begin
    if (rst_sys_i) begin
      sync_q   <= '0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
    end else begin
      sync_q   <= sync_d;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
    end
  end

  assign level_o = stable_q;
  assign rise_o  = rise_q;
  assign fall_o  = fall_q;

endmodule

// File: rtl/board_io_ctrl.sv
// Board I/O conditioning: debounced buttons/switches with edge pulses and
// glitch-free PWM LED drive from per-channel duty values.
module board_io_ctrl
  import board_io_pkg::*;
#(
  parameter int NumBtn         = 4,
  parameter int NumSw          = 4,
  parameter int DebounceCycles = DebounceCyclesDefault,
  parameter int NumPwm         = 12,
  parameter int PwmWidth       = PwmWidthDefault
) (
  input  logic                       clk_sys_i,
  input  logic                       rst_sys_i,
  input  logic [NumBtn-1:0]          btn_i,
  input  logic [NumSw-1:0]           sw_i,
  output logic [NumBtn-1:0]          btn_o,
  output logic [NumBtn-1:0]          btn_rise_o,
  output logic [NumBtn-1:0]          btn_fall_o,
  output logic [NumSw-1:0]           sw_o,
  input  logic [NumPwm*PwmWidth-1:0] pwm_duty_i,
  output logic [NumPwm-1:0]          pwm_o
);

  // Switches have no edge outputs; their pulse pins land on these sinks.
  logic [NumSw-1:0] sw_rise_unused;
  logic [NumSw-1:0] sw_fall_unused;

  for (genvar gi = 0; gi < NumBtn; gi++) begin : g_btn
    debounce_chan #(.DebounceCycles(DebounceCycles)) u_btn (
      .clk_sys_i(clk_sys_i),
      .rst_sys_i(rst_sys_i),
      .raw_i    (btn_i[gi]),
      .level_o  (btn_o[gi]),
      .rise_o   (btn_rise_o[gi]),
      .fall_o   (btn_fall_o[gi])
    );
  end

  for (genvar gi = 0; gi < NumSw; gi++) begin : g_sw
    debounce_chan #(.DebounceCycles(DebounceCycles)) u_sw (
      .clk_sys_i(clk_sys_i),
      .rst_sys_i(rst_sys_i),
      .raw_i    (sw_i[gi]),
      .level_o  (sw_o[gi]),
      .rise_o   (sw_rise_unused[gi]),
      .fall_o   (sw_fall_unused[gi])
    );
  end

  localparam logic [PwmWidth-1:0] CntMax = '1;

  logic [PwmWidth-1:0] cnt_q, cnt_d;
  logic [PwmWidth-1:0] shadow_q [NumPwm];
  logic [PwmWidth-1:0] shadow_d [NumPwm];
  logic [NumPwm-1:0]   pwm_q, pwm_d;

  // Shadows only load on the wrap cycle, so a period always runs on one duty.
  always_comb begin
    cnt_d    = cnt_q + PwmWidth'(1);
    shadow_d = shadow_q;
    pwm_d    = '0;
    for (int i = 0; i < NumPwm; i++) begin
      pwm_d[i] = (cnt_q < shadow_q[i]);
      if (cnt_q == CntMax) begin
        shadow_d[i] = pwm_duty_i[i*PwmWidth +: PwmWidth];
      end
    end
  end

  // NOTE: the shadow array is reset explicitly; reset must force every PWM output low at once.
  always_ff @(posedge clk_sys_i or posedge rst_sys_i) begin
    if (rst_sys_i) begin
      cnt_q <= '0;
      pwm_q <= '0;
      for (int i = 0; i < NumPwm; i++) begin
        shadow_q[i] <= '0;
      end
    end else begin
      cnt_q    <= cnt_d;
      pwm_q    <= pwm_d;
      shadow_q <= shadow_d;
    end
  end

  assign pwm_o = pwm_q;

endmodule

// File: tb/tb_board_io_ctrl.sv
// Self-checking bench for board_io_ctrl: directed scenarios plus random
// stimulus, checked each cycle against a window/period-based reference model.
module tb_board_io_ctrl;

  localparam int NB  = 4;
  localparam int NS  = 4;
  localparam int DB  = 4;
  localparam int NP  = 12;
  localparam int PW  = 4;
  localparam int PER = 1 << PW;
  localparam int NCH = NB + NS;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NB-1:0]     btn_i = '0;
  logic [NS-1:0]     sw_i = '0;
  logic [NB-1:0]     btn_o, btn_rise_o, btn_fall_o;
  logic [NS-1:0]     sw_o;
  logic [NP*PW-1:0]  pwm_duty_i = '0;
  logic [NP-1:0]     pwm_o;

  always #5 clk = ~clk;

  board_io_ctrl #(
    .NumBtn(NB), .NumSw(NS), .DebounceCycles(DB), .NumPwm(NP), .PwmWidth(PW)
  ) dut (
    .clk_sys_i (clk),
    .rst_sys_i (rst),
    .btn_i     (btn_i),
    .sw_i      (sw_i),
    .btn_o     (btn_o),
    .btn_rise_o(btn_rise_o),
    .btn_fall_o(btn_fall_o),
    .sw_o      (sw_o),
    .pwm_duty_i(pwm_duty_i),
    .pwm_o     (pwm_o)
  );

  int n_cmp = 0;
  int n_mis = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: pin history, per-channel stable level and last acceptance,
  // per-channel duty latched at each period boundary.
  logic [NCH-1:0] hist[$];
  logic [NCH-1:0] m_stable;
  logic [NB-1:0]  m_rise, m_fall;
  int             m_last[NCH];
  int             cyc;
  logic [PW-1:0]  m_shadow[NP];
  logic [NP-1:0]  m_pwm;

  task automatic model_reset();
    hist.delete();
    hist.push_back('0);
    m_stable = '0;
    m_rise   = '0;
    m_fall   = '0;
    cyc      = 0;
    m_pwm    = '0;
    for (int c = 0; c < NCH; c++) m_last[c] = 0;
    for (int i = 0; i < NP; i++) m_shadow[i] = '0;
  endtask

  // Filter input seen at edge n is the pin sampled two edges earlier.
  function automatic logic [NCH-1:0] fin(input int n);
    if (n - 2 >= 1) return hist[n-2];
    return '0;
  endfunction

  task automatic model_edge();
    logic [NCH-1:0] v;
    bit             all_diff;
    int             ph;
    cyc++;
    hist.push_back({sw_i, btn_i});
    m_rise = '0;
    m_fall = '0;
    // A level is accepted once the last DB filter inputs all differ from it,
    // counting only inputs that arrived after the previous acceptance.
    for (int c = 0; c < NCH; c++) begin
      if (cyc - m_last[c] >= DB) begin
        all_diff = 1'b1;
        for (int k = 0; k < DB; k++) begin
          v = fin(cyc - k);
          if (v[c] == m_stable[c]) all_diff = 1'b0;
        end
        if (all_diff) begin
          m_stable[c] = ~m_stable[c];
          m_last[c]   = cyc;
          if (c < NB) begin
            m_rise[c] = m_stable[c];
            m_fall[c] = ~m_stable[c];
          end
        end
      end
    end
    ph = (cyc - 1) % PER;
    for (int i = 0; i < NP; i++) begin
      m_pwm[i] = (ph < int'(m_shadow[i]));
      if (ph == PER - 1) m_shadow[i] = pwm_duty_i[i*PW +: PW];
    end
  endtask

  task automatic step();
    @(posedge clk);
    if (!rst) model_edge();
    #1;
    check("btn_o",      32'(btn_o),      32'(m_stable[NB-1:0]));
    check("sw_o",       32'(sw_o),       32'(m_stable[NCH-1:NB]));
    check("btn_rise_o", 32'(btn_rise_o), 32'(m_rise));
    check("btn_fall_o", 32'(btn_fall_o), 32'(m_fall));
    check("pwm_o",      32'(pwm_o),      32'(m_pwm));
  endtask

  task automatic set_duty(input int ch, input int val);
    pwm_duty_i[ch*PW +: PW] = PW'(val);
  endtask

  task automatic align();
    while (cyc % PER != 0) step();
  endtask

  int highs[NP];

  task automatic measure_period();
    for (int i = 0; i < NP; i++) highs[i] = 0;
    repeat (PER) begin
      step();
      for (int i = 0; i < NP; i++) highs[i] += int'(pwm_o[i]);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int rises;
    int acc;
    logic [7:0] pat;

    model_reset();
    repeat (3) step();
    @(negedge clk);
    rst = 1'b0;

    // Clean press and release on button 0: edge DB+2 cycles after the pin.
    repeat (3) step();
    btn_i[0] = 1'b1;
    k = 0;
    while (!btn_o[0] && k < 20) begin step(); k++; end
    check("press_latency", 32'(k), 32'(DB + 2));
    check("press_rise", 32'(btn_rise_o[0]), 32'(1));
    step();
    check("rise_width", 32'(btn_rise_o[0]), 32'(0));
    btn_i[0] = 1'b0;
    k = 0;
    while (btn_o[0] && k < 20) begin step(); k++; end
    check("release_latency", 32'(k), 32'(DB + 2));
    check("release_fall", 32'(btn_fall_o[0]), 32'(1));

    // Bounce on button 1: pattern 1,1,1,0,1,1,1,1 then held high.
    pat   = 8'b1111_0111;
    rises = 0;
    k     = 0;
    for (int j = 0; j < 20; j++) begin
      btn_i[1] = (j < 8) ? pat[j] : 1'b1;
      step();
      rises += int'(btn_rise_o[1]);
      if (btn_o[1] && k == 0) k = j + 1;
    end
    check("bounce_latency", 32'(k), 32'(10));
    check("bounce_rises", 32'(rises), 32'(1));

    // PWM duty patterns on a 16-cycle period.
    set_duty(0, 5);
    set_duty(1, 0);
    set_duty(2, 15);
    step();
    align();
    measure_period();
    check("duty5_highs",  32'(highs[0]), 32'(5));
    check("duty0_highs",  32'(highs[1]), 32'(0));
    check("duty15_highs", 32'(highs[2]), 32'(15));

    // Duty change mid-period only takes effect at the next boundary.
    set_duty(3, 3);
    step();
    align();
    acc = 0;
    repeat (7) begin step(); acc += int'(pwm_o[3]); end
    set_duty(3, 12);
    repeat (PER - 7) begin step(); acc += int'(pwm_o[3]); end
    check("glitch_cur_period", 32'(acc), 32'(3));
    measure_period();
    check("glitch_next_period", 32'(highs[3]), 32'(12));

    // All channels at distinct duties with all buttons pressed together.
    for (int i = 0; i < NP; i++) set_duty(i, i);
    btn_i = '1;
    step();
    align();
    measure_period();
    for (int i = 0; i < NP; i++) check($sformatf("multi_duty%0d", i), 32'(highs[i]), 32'(i));
    repeat (10) step();
    check("multi_btn_level", 32'(btn_o), 32'({NB{1'b1}}));

    // Random pins and duties, checked cycle by cycle against the model.
    for (int j = 0; j < 600; j++) begin
      if ($urandom_range(7) == 0) sw_i[$urandom_range(NS-1)] ^= 1'b1;
      if ($urandom_range(19) == 0) btn_i[$urandom_range(NB-1)] ^= 1'b1;
      if ($urandom_range(29) == 0) set_duty($urandom_range(NP-1), $urandom_range(PER-1));
      step();
    end

    // Reset mid-run with non-zero duties, levels and counts.
    for (int i = 0; i < NP; i++) set_duty(i, $urandom_range(PER-1, 1));
    btn_i = '1;
    sw_i  = '1;
    repeat (2 * PER) step();
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst_btn_o",  32'(btn_o),      32'(0));
    check("rst_sw_o",   32'(sw_o),       32'(0));
    check("rst_rise",   32'(btn_rise_o), 32'(0));
    check("rst_fall",   32'(btn_fall_o), 32'(0));
    check("rst_pwm_o",  32'(pwm_o),      32'(0));
    model_reset();
    repeat (2) step();
    @(negedge clk);
    rst = 1'b0;
    repeat (3 * PER) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
